muldiv_unit: RTL and testbench



---
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request / write-back bundle between issue control, the register
// file and the iterative multiply/divide unit.
//   start_i, funct3_i, rd_i, rs1_data_i, rs2_data_i : request (master -> slave)
//   busy_o, done_o, we_o, addwrite_o, datowrite_o   : status / write-back (slave -> master)
interface muldiv_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
);
  logic             start_i;
  logic [2:0]       funct3_i;
  logic [DEPTH-1:0] rd_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             busy_o;
  logic             done_o;
  logic             we_o;
  logic [DEPTH-1:0] addwrite_o;
  logic [WIDTH-1:0] datowrite_o;

  modport master (
    output start_i, funct3_i, rd_i, rs1_data_i, rs2_data_i,
    input  busy_o, done_o, we_o, addwrite_o, datowrite_o
  );

  modport slave (
    input  start_i, funct3_i, rd_i, rs1_data_i, rs2_data_i,
    output busy_o, done_o, we_o, addwrite_o, datowrite_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. One operation at a time;
// shift-add multiply or restoring divide over WIDTH cycles on operand
// magnitudes, sign fix-up in a single cycle, then a one-cycle write-back pulse.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous reset, active high (aborts any operation in flight)
//   bus    - muldiv_if.slave: request in, busy/done/write-back out
//
// state  | meaning
// IDLE   | waiting for start_i; operands latched on acceptance
// CALC   | WIDTH iterations, one per cycle
// FIX    | sign correction, result select, special cases; result registered
// DONE   | done_o pulse, we_o unless rd = x0
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [DEPTH-1:0]   rd_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q;
  logic               dz_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   res_q;

  // Acceptance decode
  logic             a_signed, b_signed, a_neg, b_neg, neg_start;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    a_signed  = (bus.funct3_i == OP_MULH) || (bus.funct3_i == OP_MULHSU) ||
                (bus.funct3_i == OP_DIV)  || (bus.funct3_i == OP_REM);
    b_signed  = (bus.funct3_i == OP_MULH) || (bus.funct3_i == OP_DIV) ||
                (bus.funct3_i == OP_REM);
    a_neg     = a_signed && bus.rs1_data_i[WIDTH-1];
    b_neg     = b_signed && bus.rs2_data_i[WIDTH-1];
    mag_a     = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
    mag_b     = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
    // remainder takes the dividend's sign; everything else the XOR
    neg_start = (bus.funct3_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  // Iteration step. acc holds {partial product high, multiplier} for multiply
  // and {partial remainder, remaining dividend / quotient bits} for divide.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    // borrow out means the divisor did not fit: plain shift, quotient bit 0
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Fix-up and result select
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, result;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    result   = '0;
    case (op_q)
      OP_MUL:                        result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: begin
        if (dz_q)       result = '1;
        else if (ovf_q) result = MOST_NEG;
        else            result = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (dz_q)       result = a_q;
        else if (ovf_q) result = '0;
        else            result = rem_fix;
      end
      default:                       result = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      a_q   <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
      res_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            op_q  <= bus.funct3_i;
            rd_q  <= bus.rd_i;
            a_q   <= bus.rs1_data_i;
            neg_q <= neg_start;
            dz_q  <= (bus.rs2_data_i == '0);
            // signed overflow only exists for DIV/REM
            ovf_q <= ((bus.funct3_i == OP_DIV) || (bus.funct3_i == OP_REM)) &&
                     (bus.rs1_data_i == MOST_NEG) && (&bus.rs2_data_i);
            cnt   <= '0;
            if (bus.funct3_i[2]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= op_q[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          res_q <= result;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o      = (state != S_IDLE);
  assign bus.done_o      = (state == S_DONE);
  assign bus.we_o        = (state == S_DONE) && (rd_q != '0);
  assign bus.addwrite_o  = rd_q;
  assign bus.datowrite_o = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int LAT   = WIDTH + 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  muldiv_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  muldiv_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] da, db;
    logic ovf;
    ea  = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
    eb  = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = ea * eb;
    da  = a;
    db  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(da / db);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(da % db);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit push);
    exp_t e;
    bus.start_i    = 1'b1;
    bus.funct3_i   = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_i       = rd;
    if (push) begin
      e.data = exp;
      e.rd   = rd;
      sbq.push_back(e);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Starting at the negedge of cycle 1, wait for done_o and score it.
  task automatic wait_done(input string name);
    int   lat = 1;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (!bus.done_o && lat < 100) begin
      busy_ok &= bus.busy_o;
      @(negedge clk_i);
      lat++;
    end
    check({name, "_done_seen"}, 64'(bus.done_o), 64'd1);
    busy_ok &= bus.busy_o;
    check({name, "_latency"}, 64'(lat), 64'(LAT));
    check({name, "_busy"}, 64'(busy_ok), 64'd1);
    if (sbq.size() == 0) begin
      check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    check({name, "_data"}, 64'(bus.datowrite_o), 64'(e.data));
    check({name, "_addr"}, 64'(bus.addwrite_o), 64'(e.rd));
    check({name, "_we"}, 64'(bus.we_o), 64'(e.rd != 0));
    @(negedge clk_i);
    check({name, "_after"}, {61'd0, bus.done_o, bus.busy_o, bus.we_o}, 64'd0);
    check({name, "_hold"}, 64'(bus.datowrite_o), 64'(e.data));
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[2]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         5'd7,  32'd14};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,         5'd8,  32'd2};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 32'd5,          32'd0,         5'd10, 32'd5};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
    vecs[12] = '{3'b000, 32'd3,          32'd4,         5'd0,  32'd12};
    vecs[13] = '{3'b100, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF};
    vecs[14] = '{3'b111, 32'hDEAD_BEEF,  32'd0,         5'd14, 32'hDEAD_BEEF};
    vecs[15] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd31, 32'hFFFF_FFFD};

    bus.start_i    = 1'b0;
    bus.funct3_i   = '0;
    bus.rd_i       = '0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ctrl", {61'd0, bus.busy_o, bus.done_o, bus.we_o}, 64'd0);
    check("reset_addr", 64'(bus.addwrite_o), 64'd0);
    check("reset_data", 64'(bus.datowrite_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed vectors; operands are scrambled after acceptance.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
      bus.start_i    = 1'b0;
      bus.funct3_i   = 3'($urandom);
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
      bus.rd_i       = 5'($urandom);
      wait_done($sformatf("vec%0d", i));
    end

    // Random operations against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      rd = 5'($urandom);
      issue(f, a, b, rd, ref_model(f, a, b), 1'b1);
      bus.start_i = 1'b0;
      wait_done($sformatf("rnd%0d_f%0d", i, f));
    end

    // start_i held high through an op: one completion, next op accepted right after DONE.
    issue(3'b000, 32'd6, 32'd7, 5'd3, 32'd42, 1'b1);
    bus.funct3_i   = 3'b101;
    bus.rs1_data_i = 32'd1000;
    bus.rs2_data_i = 32'd10;
    bus.rd_i       = 5'd4;
    begin
      exp_t e2;
      e2.data = 32'd100;
      e2.rd   = 5'd4;
      sbq.push_back(e2);
    end
    wait_done("held_first");
    @(posedge clk_i);
    @(negedge clk_i);
    check("held_b2b_accept", 64'(bus.busy_o), 64'd1);
    bus.start_i = 1'b0;
    wait_done("held_second");

    // Reset in cycle 10 of a DIV aborts it.
    issue(3'b100, 32'h1234_5678, 32'd3, 5'd17, 32'd0, 1'b0);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("abort_ctrl", {61'd0, bus.busy_o, bus.done_o, bus.we_o}, 64'd0);
    check("abort_addr", 64'(bus.addwrite_o), 64'd0);
    check("abort_data", 64'(bus.datowrite_o), 64'd0);
    rst_i = 1'b0;
    begin
      bit stray = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        stray |= bus.done_o | bus.we_o | bus.busy_o;
      end
      check("abort_no_writeback", 64'(stray), 64'd0);
    end
    issue(3'b111, 32'd1000, 32'd33, 5'd21, 32'd10, 1'b1);
    bus.start_i = 1'b0;
    wait_done("after_abort");

    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
